regfile_arbiter: RTL
====================

# regfile_arbiter

Round-robin arbiter and command sequencer for the 4×8-bit register file's single command port (address pair, immediate, write enable, REGOP, write data). It sits between up to four command sources (e.g. instruction decode, debug loader, terminal bridge) and the register file. It grants at most one command per cycle and registers the winning command onto the register-file inputs. Idle cycles present a guaranteed no-op.

## Interface
Parameters:
- NREQ, 2, number of requesters, legal 2..4
- CW, 24, command width (fixed; not to be overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a command on its slice
- req_cmd  in  NREQ*CW  packed commands, requester i at bits [i*CW +: CW]. Per slice:
  - [23:22] addr1
  - [21:20] addr2
  - [19:12] imm
  - [11] writereg
  - [10:8] regop
  - [7:0] wrdata
- req_lock  in  NREQ  requester i asks to keep the grant after this command (used only with REGARB_LOCK_EN)
- req_ready  out  NREQ  combinational; command i is accepted this cycle when req_valid[i] & req_ready[i]
- rf_regAddr1  out  2  registered addr1 to register file
- rf_regAddr2  out  2  registered addr2
- rf_immVal  out  8  registered imm
- rf_WRITEREG  out  1  registered writereg, 0 on idle cycles
- rf_REGOP  out  3  registered regop, 3'b000 on idle cycles
- rf_wrData  out  8  registered wrdata
- issue_valid  out  1  registered; rf_* carries an accepted command this cycle
- issue_id  out  2  registered index of the requester whose command is on rf_*
- cmd_count  out  16  number of accepted commands, wraps modulo 2^16

## Operation
- Priority pointer `ptr` (0..NREQ-1). Among asserted req_valid, the grant goes to the first index at or after `ptr`, searching cyclically.
- Exactly one req_ready bit may be high in a cycle. If no request is valid, all req_ready bits are 0.
- req_ready[i] depends only on req_valid, ptr and the lock state. It never depends on req_cmd.
- On acceptance from requester g:
  - ptr ← (g+1) mod NREQ
  - rf_* ← fields of slice g
  - issue_valid ← 1
  - issue_id ← g
  - cmd_count ← cmd_count+1
- No acceptance in a cycle:
  - rf_WRITEREG ← 0, rf_REGOP ← 0, issue_valid ← 0
  - rf_regAddr1/2, rf_immVal, rf_wrData, issue_id hold their values
  - ptr unchanged
- Requester contract: once req_valid[i] is raised, req_cmd slice i and req_lock[i] stay stable until accepted. The arbiter does not check this.
- The arbiter is pass-through on content. It does not decode regop or validate writereg+regop combinations. If both are set, the register file's own ordering applies.
- Reset (rst=1, takes priority over everything):
  - ptr=0, lock cleared, cmd_count=0
  - all rf_* = 0, issue_valid=0, issue_id=0
  - req_ready all 0 during the reset cycle
- Reset asserted mid-sequence drops any pending lock. A command presented in the same cycle as rst is not accepted.

## Timing
- Latency: the command is accepted in cycle N and appears on rf_* in cycle N+1. The register file commits it at the end of cycle N+1.
- Back-to-back: one command per cycle sustained. With all requesters valid, grants rotate 0,1,…,NREQ-1,0,…
- A single valid requester is granted every cycle it is valid. There are no bubbles.
- Read-after-write between consecutive commands is resolved by the register file's own edge ordering. The arbiter inserts no stalls.
- Out-of-range requesters: req_valid bits at index ≥ NREQ do not exist. Pointer wrap is modulo NREQ.

## Configuration
- REGARB_LOCK_EN defined:
  - An accepted command with req_lock[g]=1 sets lock_owner=g.
  - While locked, only requester g can be ready. Other requesters are held off even if valid.
  - ptr is not advanced while locked.
  - An accepted command from g with req_lock[g]=0 releases the lock. ptr then becomes (g+1) mod NREQ.
  - If g drops req_valid while locked, idle no-op cycles are issued and the lock persists.
- REGARB_LOCK_EN undefined: req_lock is ignored and there is no lock state. The block is pure round-robin.

## Test plan
- Reset, then req_valid=0 for 5 cycles → rf_REGOP=0, rf_WRITEREG=0, issue_valid=0, cmd_count=0, all req_ready=0.
- NREQ=2, both requesters continuously valid for 6 cycles → issue_id sequence 0,1,0,1,0,1 one cycle after each accept; cmd_count=6.
- Requester 1 only, command {addr1=2, regop=3'b100, imm=8'h5A} → req_ready[1]=1 the same cycle; next cycle rf_regAddr1=2, rf_REGOP=3'b100, rf_immVal=8'h5A, issue_valid=1; the cycle after, rf_REGOP=0.
- REGARB_LOCK_EN, NREQ=2:
  - req0 issues 3 commands with lock=1,1,0 while req1 is continuously valid → req_ready[1]=0 through all three.
  - req1 is granted in the cycle after req0's lock=0 command is accepted.
- rst asserted while a lock is held and both requesters are valid → the next cycle has issue_valid=0 and rf_* all 0; after rst is released, requester 0 is granted first (ptr=0).
- cmd_count preloaded by issuing 65536 commands → wraps to 0 with no effect on the grant sequence.

Source files
------------

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter and command sequencer for the register file command port
//
// Purpose: grants at most one of NREQ command sources per cycle and registers the
// winning command onto the register-file inputs. Idle cycles drive a no-op
// (WRITEREG=0, REGOP=0).
// Optional feature macro: REGARB_LOCK_EN (grant locking via req_lock).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid[NREQ]          requester i has a command on its slice
//   req_cmd[NREQ*CW]         packed commands, requester i at [i*CW +: CW]
//   req_lock[NREQ]           keep the grant after this command (lock build only)
//   req_ready[NREQ]          combinational one-hot accept
//   rf_*                     registered command fields to the register file
//   issue_valid, issue_id    registered: rf_* carries a command from requester issue_id
//   cmd_count[16]            accepted-command counter, wraps
module regfile_arbiter #(
    parameter int NREQ = 2,
    parameter int CW   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW-1:0]   req_cmd,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic [1:0]           rf_regAddr1,
    output logic [1:0]           rf_regAddr2,
    output logic [7:0]           rf_immVal,
    output logic                 rf_WRITEREG,
    output logic [2:0]           rf_REGOP,
    output logic [7:0]           rf_wrData,
    output logic                 issue_valid,
    output logic [1:0]           issue_id,
    output logic [15:0]          cmd_count
);

    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  rf_addr1_q, rf_addr1_d;
    logic [1:0]  rf_addr2_q, rf_addr2_d;
    logic [7:0]  rf_imm_q, rf_imm_d;
    logic        rf_writereg_q, rf_writereg_d;
    logic [2:0]  rf_regop_q, rf_regop_d;
    logic [7:0]  rf_wrdata_q, rf_wrdata_d;
    logic        issue_valid_q, issue_valid_d;
    logic [1:0]  issue_id_q, issue_id_d;
    logic [15:0] cmd_count_q, cmd_count_d;

`ifdef REGARB_LOCK_EN
    logic        lock_active_q, lock_active_d;
    logic [1:0]  lock_owner_q, lock_owner_d;
`else
    logic        unused_lock;
    assign unused_lock = ^req_lock;
`endif

    logic [3:0]    valid4;
    logic [3:0]    eligible;
    logic [2:0]    probe;
    logic          grant_any;
    logic [1:0]    grant_idx;
    logic [CW-1:0] sel_cmd;
    logic [2:0]    ptr_next;

    // Arbitration: first eligible index at or after ptr, searched cyclically.
    always_comb begin
        valid4    = 4'(req_valid);
        eligible  = valid4;
`ifdef REGARB_LOCK_EN
        // A held lock masks everyone except the owner.
        if (lock_active_q) begin
            eligible = valid4 & (4'b0001 << lock_owner_q);
        end
`endif
        probe     = 3'd0;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            probe = {1'b0, ptr_q} + 3'(k);
            if (probe >= 3'(NREQ)) begin
                probe = probe - 3'(NREQ);
            end
            if (!grant_any && eligible[probe[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = probe[1:0];
            end
        end
        // Nothing is accepted while reset is asserted.
        if (rst) begin
            grant_any = 1'b0;
        end

        req_ready = '0;
        sel_cmd   = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = grant_any && (grant_idx == 2'(j));
            if (grant_idx == 2'(j)) begin
                sel_cmd = req_cmd[j*CW +: CW];
            end
        end

        ptr_next = {1'b0, grant_idx} + 3'd1;
        if (ptr_next >= 3'(NREQ)) begin
            ptr_next = 3'd0;
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        rf_addr1_d    = rf_addr1_q;
        rf_addr2_d    = rf_addr2_q;
        rf_imm_d      = rf_imm_q;
        rf_wrdata_d   = rf_wrdata_q;
        issue_id_d    = issue_id_q;
        cmd_count_d   = cmd_count_q;
        rf_writereg_d = 1'b0;
        rf_regop_d    = 3'b000;
        issue_valid_d = 1'b0;
`ifdef REGARB_LOCK_EN
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
`endif
        if (grant_any) begin
            rf_addr1_d    = sel_cmd[23:22];
            rf_addr2_d    = sel_cmd[21:20];
            rf_imm_d      = sel_cmd[19:12];
            rf_writereg_d = sel_cmd[11];
            rf_regop_d    = sel_cmd[10:8];
            rf_wrdata_d   = sel_cmd[7:0];
            issue_valid_d = 1'b1;
            issue_id_d    = grant_idx;
            cmd_count_d   = cmd_count_q + 16'd1;
`ifdef REGARB_LOCK_EN
            // Locking accept keeps ptr; the releasing accept rotates past the owner.
            if (req_lock[grant_idx]) begin
                lock_active_d = 1'b1;
                lock_owner_d  = grant_idx;
            end else begin
                lock_active_d = 1'b0;
                ptr_d         = ptr_next[1:0];
            end
`else
            ptr_d         = ptr_next[1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= 2'd0;
            rf_addr1_q    <= 2'd0;
            rf_addr2_q    <= 2'd0;
            rf_imm_q      <= 8'd0;
            rf_writereg_q <= 1'b0;
            rf_regop_q    <= 3'b000;
            rf_wrdata_q   <= 8'd0;
            issue_valid_q <= 1'b0;
            issue_id_q    <= 2'd0;
            cmd_count_q   <= 16'd0;
`ifdef REGARB_LOCK_EN
            lock_active_q <= 1'b0;
            lock_owner_q  <= 2'd0;
`endif
        end else begin
            ptr_q         <= ptr_d;
            rf_addr1_q    <= rf_addr1_d;
            rf_addr2_q    <= rf_addr2_d;
            rf_imm_q      <= rf_imm_d;
            rf_writereg_q <= rf_writereg_d;
            rf_regop_q    <= rf_regop_d;
            rf_wrdata_q   <= rf_wrdata_d;
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            cmd_count_q   <= cmd_count_d;
`ifdef REGARB_LOCK_EN
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
`endif
        end
    end

    assign rf_regAddr1 = rf_addr1_q;
    assign rf_regAddr2 = rf_addr2_q;
    assign rf_immVal   = rf_imm_q;
    assign rf_WRITEREG = rf_writereg_q;
    assign rf_REGOP    = rf_regop_q;
    assign rf_wrData   = rf_wrdata_q;
    assign issue_valid = issue_valid_q;
    assign issue_id    = issue_id_q;
    assign cmd_count   = cmd_count_q;

endmodule
